// File: rtl/adder_cell_response_checker_if.sv
// adder_cell_response_checker_if: observation channel from the adder cell into the checker
//   valid : tuple present (master -> slave)
//   ready : checker accepts tuple this cycle (slave -> master)
//   a,b,c : adder-cell inputs as applied
//   d,e   : adder-cell outputs as observed (sum, carry)
interface adder_cell_response_checker_if;
  logic valid;
  logic ready;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  modport master (output valid, a, b, c, d, e, input ready);
  modport slave (input valid, a, b, c, d, e, output ready);
endinterface

// File: rtl/adder_cell_response_checker.sv
// adder_cell_response_checker: checks observed adder-cell tuples (d = sum, e = carry), counts vectors/errors,
// tracks input coverage, captures the first failure and reports pass/fail.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : one-cycle pulse, begins a run from IDLE or DONE
//   obs               : observation channel (slave side)
//   busy, done, pass  : run status; pass is valid while done=1
//   vec_count         : tuples accepted this run
//   err_count         : mismatching tuples this run, saturating
//   coverage          : bit {a,b,c} set once that combination is accepted
//   first_fail(_valid): {a,b,c,d,e} of the first mismatching tuple
module adder_cell_response_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  adder_cell_response_checker_if.slave obs,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          vec_count,
  output logic [ERR_W-1:0]          err_count,
  output logic [7:0]                coverage,
  output logic [4:0]                first_fail,
  output logic                      first_fail_valid
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic acc, mis, last;
  logic [2:0] idx;
  logic [ERR_W-1:0] err_next;
  logic [7:0] cov_next;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
    obs.ready = busy;
    acc = obs.valid & busy;
    idx = {obs.a, obs.b, obs.c};
    mis = (obs.d != ^idx) | (obs.e != (obs.a & obs.b | obs.a & obs.c | obs.b & obs.c));
    last = acc & (vec_count == CNT_W'(NUM_VECTORS - 1));
    err_next = (mis & ~&err_count) ? err_count + 1'b1 : err_count;
    cov_next = coverage | (8'd1 << idx);
  end
  // pass is evaluated on the next-state counts so the final tuple is included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vec_count <= '0;
      err_count <= '0;
      coverage <= '0;
      first_fail <= '0;
      first_fail_valid <= 1'b0;
      pass <= 1'b0;
    end else if (start && state != RUN) begin
      state <= RUN;
      vec_count <= '0;
      err_count <= '0;
      coverage <= '0;
      first_fail <= '0;
      first_fail_valid <= 1'b0;
      pass <= 1'b0;
    end else if (acc) begin
      vec_count <= vec_count + 1'b1;
      err_count <= err_next;
      coverage <= cov_next;
      if (mis && !first_fail_valid) begin
        first_fail <= {idx, obs.d, obs.e};
        first_fail_valid <= 1'b1;
      end
      if (last) begin
        state <= DONE;
        pass <= (err_next == '0) & (&cov_next);
      end
    end
  end
endmodule

// File: tb/tb_adder_cell_response_checker.sv
// tb_adder_cell_response_checker: table-driven, hand-sequenced and randomized checks against a behavioural model
module tb_adder_cell_response_checker;
  logic clk = 1'b0;
  logic rst_n, start, start2;
  logic busy, done, pass, first_fail_valid;
  logic [7:0] vec_count, err_count, coverage;
  logic [4:0] first_fail;
  logic busy2, done2, pass2, ffv2;
  logic [7:0] vec2, cov2;
  logic [1:0] err2;
  logic [4:0] ff2;
  int n_vec = 0;
  int n_bad = 0;
  adder_cell_response_checker_if ifc ();
  adder_cell_response_checker_if if2 ();
  adder_cell_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .obs(ifc.slave),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .coverage(coverage), .first_fail(first_fail), .first_fail_valid(first_fail_valid)
  );
  adder_cell_response_checker #(.NUM_VECTORS(5), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .obs(if2.slave),
    .busy(busy2), .done(done2), .pass(pass2), .vec_count(vec2), .err_count(err2),
    .coverage(cov2), .first_fail(ff2), .first_fail_valid(ffv2)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] tv;
    logic [7:0]  err;
    logic [7:0]  cov;
    logic        pass;
    logic        ffv;
    logic [4:0]  ff;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] t);
    ifc.valid = 1'b1;
    {ifc.a, ifc.b, ifc.c, ifc.d, ifc.e} = t;
    tick();
    ifc.valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected results computed from the tuple list with plain arithmetic
  function automatic vec_t model(input logic [39:0] tv);
    vec_t r;
    int s, err;
    logic [4:0] t;
    r = '0;
    r.tv = tv;
    err = 0;
    for (int i = 0; i < 8; i++) begin
      t = tv[39-5*i -: 5];
      s = int'(t[4]) + int'(t[3]) + int'(t[2]);
      if (int'(t[1]) != s % 2 || int'(t[0]) != (s >= 2 ? 1 : 0)) begin
        err = (err < 255) ? err + 1 : 255;
        if (!r.ffv) begin
          r.ff = t;
          r.ffv = 1'b1;
        end
      end
      r.cov[t[4:2]] = 1'b1;
    end
    r.err = 8'(err);
    r.pass = (err == 0) && (r.cov == 8'hFF);
    return r;
  endfunction

  task automatic run8(input logic [39:0] tv, input bit gaps);
    pulse_start();
    chk("cleared_vec_count", 32'(vec_count), 0);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send(tv[39-5*i -: 5]);
    end
  endtask

  task automatic check_res(input string tag, input vec_t e);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(ifc.ready), 0);
    chk({tag, "_vec_count"}, 32'(vec_count), 8);
    chk({tag, "_err_count"}, 32'(err_count), 32'(e.err));
    chk({tag, "_coverage"}, 32'(coverage), 32'(e.cov));
    chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
    chk({tag, "_ffv"}, 32'(first_fail_valid), 32'(e.ffv));
    if (e.ffv) chk({tag, "_first_fail"}, 32'(first_fail), 32'(e.ff));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(ifc.ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_vec_count"}, 32'(vec_count), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_coverage"}, 32'(coverage), 0);
    chk({tag, "_ffv"}, 32'(first_fail_valid), 0);
    chk({tag, "_first_fail"}, 32'(first_fail), 0);
  endtask

  initial begin
    logic [39:0] tv;
    logic [2:0] ord [8];
    logic [2:0] tmp;
    int j, s;
    // Correct tuples {a,b,c,d,e}: 000->00000 111->11111 001->00110 010->01010
    // 011->01101 100->10010 101->10101 110->11001
    tbl[0] = '{40'b00000_11111_00110_01010_01101_10010_10101_11001, 8'd0, 8'hFF, 1'b1, 1'b0, 5'b00000};
    tbl[1] = '{40'b00000_11101_00110_01010_01111_10010_10101_11001, 8'd2, 8'hFF, 1'b0, 1'b1, 5'b11101};
    tbl[2] = '{40'b00000_00000_11111_00110_01010_01101_10010_10101, 8'd0, 8'hBF, 1'b0, 1'b0, 5'b00000};
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    ifc.valid = 1'b0; {ifc.a, ifc.b, ifc.c, ifc.d, ifc.e} = '0;
    if2.valid = 1'b0; {if2.a, if2.b, if2.c, if2.d, if2.e} = '0;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run8(tbl[i].tv, 1'b0);
      check_res($sformatf("table%0d", i), tbl[i]);
    end

    // Offers in IDLE are dropped; then alternating valid in RUN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (4) send(5'b00000);
    chk("idle_vec_count", 32'(vec_count), 0);
    chk("idle_ready", 32'(ifc.ready), 0);
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      ifc.valid = (k % 2 == 0);
      {ifc.a, ifc.b, ifc.c, ifc.d, ifc.e} = tbl[0].tv[39-5*(k/2) -: 5];
      tick();
      if (k == 12) chk("toggle_not_done_after_7", 32'(done), 0);
      if (k == 14) chk("toggle_done_after_8", 32'(done), 1);
    end
    ifc.valid = 1'b0;
    check_res("toggle", tbl[0]);
    repeat (3) send(5'b00000);
    chk("done_drop_vec_count", 32'(vec_count), 8);
    chk("done_hold", 32'(done), 1);
    chk("done_hold_pass", 32'(pass), 1);

    // Reset mid-run discards the partial run
    pulse_start();
    for (int i = 0; i < 3; i++) send(tbl[0].tv[39-5*i -: 5]);
    chk("partial_vec_count", 32'(vec_count), 3);
    start = 1'b1;
    send(5'b11111);
    start = 1'b0;
    chk("start_ignored_in_run", 32'(vec_count), 4);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_zero("midrun_reset");
    run8(tbl[0].tv, 1'b0);
    check_res("after_reset", tbl[0]);

    // Saturating error counter on a 2-bit instance with 5-vector runs
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tv[24:0] = 25'b00001_11110_00111_01011_01100;
      if2.valid = 1'b1;
      {if2.a, if2.b, if2.c, if2.d, if2.e} = tv[24-5*i -: 5];
      tick();
      if (i == 3) chk("sat_not_done_after_4", 32'(done2), 0);
    end
    if2.valid = 1'b0;
    chk("sat_err_count", 32'(err2), 3);
    chk("sat_done", 32'(done2), 1);
    chk("sat_pass", 32'(pass2), 0);
    chk("sat_vec_count", 32'(vec2), 5);
    chk("sat_first_fail", 32'(ff2), 32'(5'b00001));
    start2 = 1'b1; tick(); start2 = 1'b0;
    chk("restart_err_count", 32'(err2), 0);
    chk("restart_vec_count", 32'(vec2), 0);
    chk("restart_busy", 32'(busy2), 1);

    // Randomized runs: shuffled full coverage or random inputs, occasional corrupted outputs, random gaps
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 8; i++) ord[i] = (r % 2 == 0) ? 3'(i) : 3'($urandom_range(0, 7));
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      for (int i = 0; i < 8; i++) begin
        s = int'(ord[i][2]) + int'(ord[i][1]) + int'(ord[i][0]);
        tv[39-5*i -: 5] = {ord[i], 1'(s % 2), 1'(s >= 2)};
        if ($urandom_range(0, 5) == 0) tv[39-5*i-3 -: 2] = tv[39-5*i-3 -: 2] ^ 2'($urandom_range(1, 3));
      end
      run8(tv, 1'b1);
      check_res($sformatf("rand%0d", r), model(tv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/adder_cell_response_checker.md
Name: adder_cell_response_checker

Overview:
- Synthesizable receiving end of the 3-input adder-cell vector flow: consumes observed tuples {a,b,c,d,e} and checks d = a^b^c and e = majority(a,b,c).
- Counts vectors and mismatches, tracks coverage of all 8 input combinations, captures the first failing tuple, and reports pass/fail.
- Sits after the adder cell in self-checking builds, replacing console-only monitoring.

Parameters:
- NUM_VECTORS, 8, number of accepted tuples that completes a run; 1..2^CNT_W-1.
- CNT_W, 8, width of vec_count.
- ERR_W, 8, width of err_count; saturating.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- obs_valid  in  1  observation tuple valid
- obs_ready  out  1  checker accepts tuple this cycle
- obs_a, obs_b, obs_c  in  1 each  adder-cell inputs as applied
- obs_d, obs_e  in  1 each  adder-cell outputs as observed (sum, carry)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done=1; 1 = zero errors and full coverage
- vec_count  out  CNT_W  tuples accepted this run
- err_count  out  ERR_W  mismatching tuples this run, saturating
- coverage  out  8  bit {a,b,c} (a = MSB of index) set once that combination is accepted
- first_fail  out  5  {a,b,c,d,e} of the first mismatching tuple
- first_fail_valid  out  1  first_fail holds data

Behaviour:
- Reset:
  - rst_n=0 sampled at a clk edge forces state IDLE.
  - All outputs become 0 on that edge, including obs_ready, counters, coverage, first_fail and pass.
  - Reset overrides everything, including mid-run; the partial run is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - obs_ready=0; obs_valid is ignored.
  - start=1 -> RUN next cycle; vec_count, err_count, coverage, first_fail, first_fail_valid and pass are cleared on the same edge.
- RUN:
  - busy=1, obs_ready=1 (combinational from state).
  - Accept = obs_valid & obs_ready.
  - On accept:
    - vec_count++.
    - coverage[{a,b,c}] <= 1.
    - mismatch = (obs_d != a^b^c) | (obs_e != (a&b | a&c | b&c)).
    - On mismatch: err_count++ (holds at all-ones); if first_fail_valid=0, capture first_fail and set first_fail_valid.
  - All updates are registered; counts are visible the cycle after accept.
  - start is ignored in RUN.
  - The accept that brings vec_count to NUM_VECTORS moves to DONE on the same edge; obs_ready is 0 from the next cycle.
- DONE:
  - done=1, busy=0, obs_ready=0.
  - pass = (err_count==0) & (coverage==8'hFF), registered on entry to DONE and including the final tuple.
  - All results hold until start or reset.
  - start=1 -> clear as in IDLE, enter RUN.
- Latency: done and pass assert the cycle after the final accept.
- Boundaries:
  - Duplicate combinations are allowed; coverage ORs and does not count.
  - Back-to-back accepts are supported at one per cycle.
  - Gaps in obs_valid do not advance anything.
  - Tuples offered in IDLE or DONE are dropped and not counted.
  - Only the first failure is captured; later failures only increment err_count.

Test Plan:
- Reset; start; 8 correct tuples back-to-back, inputs in order 000,111,001,010,011,100,101,110 -> done one cycle after 8th accept, vec_count=8, err_count=0, coverage=8'hFF, pass=1, first_fail_valid=0.
- Same sequence with tuple #2 = a,b,c=111, d=0, e=1 and tuple #5 = 011, d=1, e=1 -> err_count=2, first_fail=5'b11101, first_fail_valid=1, pass=0.
- 8 correct tuples with 000 sent twice and 110 missing -> err_count=0, coverage=8'hBF, pass=0.
- obs_valid=1 for 4 cycles in IDLE, then start, then valid toggled 1/0 over 16 cycles -> nothing counted in IDLE; done after the 8th valid-high cycle in RUN; obs_ready=0 in DONE.
- rst_n=0 for one cycle after 3 accepts -> next cycle all outputs 0, state IDLE; start plus 8 correct tuples -> pass=1.
- ERR_W=2, NUM_VECTORS=5, all 5 tuples wrong -> err_count saturates at 3, pass=0; start again from DONE clears err_count to 0.
